// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, default line geometry and bus-address helper
// for the data-cache miss sequencer.
`default_nettype none

package dcache_pkg;

  localparam int ADDR_W         = 32;
  localparam int WORDS_PER_LINE = 4;
  localparam int INDEX_W        = 5;
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE);
  localparam int TAG_W          = ADDR_W - INDEX_W - WORD_IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    UPDATE    = 2'd3
  } DCacheState;

  // Builds {tag, index, word, 2'b00}; the caller truncates to its address width.
  function automatic logic [63:0] compose_addr(
    input logic [63:0] tag,
    input logic [63:0] index,
    input logic [63:0] word,
    input int          index_w,
    input int          word_idx_w
  );
    return ((((tag << index_w) | index) << word_idx_w) | word) << 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_beat_counter.sv
// dcache_beat_counter: line word counter with clear/enable and a last-beat
// flag, shared by the write-back and refill phases.
`default_nettype none

module dcache_beat_counter #(
  parameter  int WORDS_PER_LINE = 4,
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  last
);

  // Clear wins over enable so the final beat of a phase lands on word 0.
  always_ff @(posedge clk) begin
    if (!rst_n)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + WORD_IDX_W'(1);
  end

  assign last = (count == WORD_IDX_W'(WORDS_PER_LINE - 1));

endmodule

`default_nettype wire

// File: rtl/dcache_miss_sequencer.sv
// dcache_miss_sequencer: stalls the M stage on a data-cache miss, writes back
// a dirty victim, refills the line and updates the tag (write-back, write-allocate).
`default_nettype none

module dcache_miss_sequencer
  import dcache_pkg::DCacheState, dcache_pkg::IDLE, dcache_pkg::WRITEBACK,
         dcache_pkg::REFILL, dcache_pkg::UPDATE, dcache_pkg::compose_addr;
#(
  parameter  int ADDR_W         = dcache_pkg::ADDR_W,
  parameter  int WORDS_PER_LINE = dcache_pkg::WORDS_PER_LINE,
  parameter  int INDEX_W        = dcache_pkg::INDEX_W,
  localparam int WORD_IDX_W     = $clog2(WORDS_PER_LINE),
  localparam int TAG_W          = ADDR_W - INDEX_W - WORD_IDX_W - 2
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iLoad,
  input  logic                  iStore,
  input  logic [ADDR_W-1:0]     iAddr,
  input  logic                  iHit,
  input  logic                  iDirty,
  input  logic [TAG_W-1:0]      iVictimTag,
  output logic                  oStall,
  output logic                  oBusReq,
  output logic                  oBusWe,
  output logic [ADDR_W-1:0]     oBusAddr,
  input  logic                  iBusAck,
  output logic [WORD_IDX_W-1:0] oWordIdx,
  output logic                  oRefillWe,
  output logic                  oTagWe,
  output logic                  oBusy
);

  DCacheState state, next_state;

  logic [TAG_W-1:0]      tag_q;
  logic [INDEX_W-1:0]    index_q;
  logic [TAG_W-1:0]      victim_tag_q;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  last_beat;
  logic                  miss;
  logic                  in_bus;
  logic                  beat_ack;
  logic                  counter_clear;
  logic [TAG_W-1:0]      bus_tag;
  logic                  unused_addr_bits;

  assign miss          = (iLoad | iStore) & ~iHit;
  assign in_bus        = (state == WRITEBACK) || (state == REFILL);
  assign beat_ack      = in_bus & iBusAck;
  assign counter_clear = (state == IDLE) || (beat_ack && last_beat);
  assign unused_addr_bits = ^{iAddr[WORD_IDX_W+1:0]};

  dcache_beat_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_beat_counter (
    .clk   (iClk),
    .rst_n (iRstN),
    .clear (counter_clear),
    .enable(beat_ack),
    .count (word_idx),
    .last  (last_beat)
  );

  always_ff @(posedge iClk) begin
    if (!iRstN)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Request fields are captured only when the miss is first seen in IDLE.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      tag_q        <= '0;
      index_q      <= '0;
      victim_tag_q <= '0;
    end else if (state == IDLE && miss) begin
      tag_q        <= iAddr[ADDR_W-1 -: TAG_W];
      index_q      <= iAddr[WORD_IDX_W+2 +: INDEX_W];
      victim_tag_q <= iVictimTag;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (miss) next_state = iDirty ? WRITEBACK : REFILL;
      WRITEBACK: if (beat_ack && last_beat) next_state = REFILL;
      REFILL:    if (beat_ack && last_beat) next_state = UPDATE;
      UPDATE:    next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    bus_tag   = (state == WRITEBACK) ? victim_tag_q : tag_q;
    oStall    = (state != IDLE) || (iRstN && miss);
    oBusy     = (state != IDLE);
    oBusReq   = in_bus;
    oBusWe    = (state == WRITEBACK);
    oBusAddr  = '0;
    oWordIdx  = word_idx;
    oRefillWe = (state == REFILL) && iBusAck;
    oTagWe    = (state == UPDATE);
    if (in_bus)
      oBusAddr = ADDR_W'(compose_addr(64'(bus_tag), 64'(index_q), 64'(word_idx),
                                      INDEX_W, WORD_IDX_W));
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_miss_sequencer.sv
// tb_dcache_miss_sequencer: directed, self-checking bench for the miss sequencer
// with hand-computed bus addresses and per-cycle control expectations.
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_miss_sequencer;

  localparam int ADDR_W     = 32;
  localparam int WPL        = 4;
  localparam int INDEX_W    = 5;
  localparam int WORD_IDX_W = 2;
  localparam int TAG_W      = 23;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load = 1'b0;
  logic              store = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              hit = 1'b0;
  logic              dirty = 1'b0;
  logic [TAG_W-1:0]  victim_tag = '0;
  logic              bus_ack = 1'b0;

  logic                  stall;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  refill_we;
  logic                  tag_we;
  logic                  busy;

  int checks = 0;
  int errors = 0;
  int refill_pulses = 0;

  always #5 clk = ~clk;

  dcache_miss_sequencer #(
    .ADDR_W(ADDR_W), .WORDS_PER_LINE(WPL), .INDEX_W(INDEX_W)
  ) dut (
    .iClk(clk), .iRstN(rst_n), .iLoad(load), .iStore(store), .iAddr(addr),
    .iHit(hit), .iDirty(dirty), .iVictimTag(victim_tag), .oStall(stall),
    .oBusReq(bus_req), .oBusWe(bus_we), .oBusAddr(bus_addr), .iBusAck(bus_ack),
    .oWordIdx(word_idx), .oRefillWe(refill_we), .oTagWe(tag_we), .oBusy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic we, input logic [31:0] a,
                      input logic [1:0] idx, input logic ack);
    bus_ack = ack;
    #1;
    chk({tag, ".req"},   bus_req, 1);
    chk({tag, ".we"},    bus_we, we);
    chk({tag, ".addr"},  bus_addr, a);
    chk({tag, ".idx"},   word_idx, idx);
    chk({tag, ".rfwe"},  refill_we, ~we & ack);
    chk({tag, ".stall"}, stall, 1);
    chk({tag, ".busy"},  busy, 1);
    chk({tag, ".tagwe"}, tag_we, 0);
    if (refill_we) refill_pulses++;
    tick();
  endtask

  task automatic idle_miss(input string tag);
    #1;
    chk({tag, ".stall"}, stall, 1);
    chk({tag, ".busy"},  busy, 0);
    chk({tag, ".req"},   bus_req, 0);
    chk({tag, ".rfwe"},  refill_we, 0);
    tick();
  endtask

  task automatic update_cycle(input string tag);
    bus_ack = 1'b0;
    #1;
    chk({tag, ".tagwe"}, tag_we, 1);
    chk({tag, ".stall"}, stall, 1);
    chk({tag, ".busy"},  busy, 1);
    chk({tag, ".req"},   bus_req, 0);
    tick();
  endtask

  task automatic hit_cycle(input string tag);
    hit = 1'b1;
    #1;
    chk({tag, ".stall"}, stall, 0);
    chk({tag, ".busy"},  busy, 0);
    chk({tag, ".req"},   bus_req, 0);
    chk({tag, ".tagwe"}, tag_we, 0);
    tick();
  endtask

  initial begin
    // reset state
    tick();
    tick();
    #1;
    chk("rst.stall", stall, 0);
    chk("rst.req",   bus_req, 0);
    chk("rst.busy",  busy, 0);
    chk("rst.tagwe", tag_we, 0);
    chk("rst.rfwe",  refill_we, 0);
    chk("rst.addr",  bus_addr, 0);
    chk("rst.idx",   word_idx, 0);
    rst_n = 1'b1;
    tick();

    // hits never stall
    load = 1'b1; hit = 1'b1; addr = 32'h0000_1234;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hit.stall", stall, 0);
      chk("hit.req",   bus_req, 0);
      tick();
    end

    // clean load miss at 0x1234: tag 0x9, index 3
    hit = 1'b0; dirty = 1'b0; victim_tag = 23'h77;
    idle_miss("clean.miss");
    addr = 32'hFFFF_FFFF; hit = 1'b1; dirty = 1'b1; victim_tag = '1;
    for (int k = 0; k < 4; k++)
      beat("clean.rf", 1'b0, 32'(32'h1230 + 4 * k), 2'(k), 1'b1);
    update_cycle("clean.upd");
    addr = 32'h0000_1234;
    hit_cycle("clean.hit");
    load = 1'b0;

    // dirty store miss: victim tag 0x2A, index 3, new tag 0x55
    store = 1'b1; hit = 1'b0; dirty = 1'b1; victim_tag = 23'h2A; addr = 32'h0000_AA38;
    idle_miss("dirty.miss");
    addr = 32'h0; dirty = 1'b0; victim_tag = 23'h11;
    for (int k = 0; k < 4; k++)
      beat("dirty.wb", 1'b1, 32'(32'h5430 + 4 * k), 2'(k), 1'b1);
    for (int k = 0; k < 4; k++)
      beat("dirty.rf", 1'b0, 32'(32'hAA30 + 4 * k), 2'(k), 1'b1);
    update_cycle("dirty.upd");
    addr = 32'h0000_AA38;
    hit_cycle("dirty.hit");
    store = 1'b0;

    // back-pressure: ack every third cycle, address/index must hold
    load = 1'b1; hit = 1'b0; dirty = 1'b0; addr = 32'h0000_2040;
    refill_pulses = 0;
    idle_miss("bp.miss");
    for (int k = 0; k < 4; k++) begin
      beat("bp.wait0", 1'b0, 32'(32'h2040 + 4 * k), 2'(k), 1'b0);
      beat("bp.wait1", 1'b0, 32'(32'h2040 + 4 * k), 2'(k), 1'b0);
      beat("bp.ack",   1'b0, 32'(32'h2040 + 4 * k), 2'(k), 1'b1);
    end
    chk("bp.pulses", refill_pulses, 4);
    update_cycle("bp.upd");
    hit_cycle("bp.hit");
    load = 1'b0;

    // reset in the middle of a refill
    load = 1'b1; hit = 1'b0; dirty = 1'b0; addr = 32'h0000_3000;
    idle_miss("rst.miss");
    beat("rstm.rf", 1'b0, 32'h0000_3000, 2'd0, 1'b1);
    beat("rstm.rf", 1'b0, 32'h0000_3004, 2'd1, 1'b1);
    load = 1'b0; bus_ack = 1'b0; rst_n = 1'b0;
    tick();
    #1;
    chk("rstm.req",   bus_req, 0);
    chk("rstm.stall", stall, 0);
    chk("rstm.busy",  busy, 0);
    chk("rstm.tagwe", tag_we, 0);
    rst_n = 1'b1;
    tick();
    load = 1'b1; hit = 1'b0; addr = 32'h0000_3000;
    idle_miss("rstm.remiss");
    for (int k = 0; k < 4; k++)
      beat("rstm.rf2", 1'b0, 32'(32'h3000 + 4 * k), 2'(k), 1'b1);
    update_cycle("rstm.upd");
    hit_cycle("rstm.hit");
    load = 1'b0;

    // stray ack in IDLE, then load+store together on a miss
    hit = 1'b0; bus_ack = 1'b1;
    #1;
    chk("stray.busy", busy, 0);
    chk("stray.req",  bus_req, 0);
    chk("stray.rfwe", refill_we, 0);
    tick();
    #1;
    chk("stray.busy2",  busy, 0);
    chk("stray.stall2", stall, 0);
    tick();
    load = 1'b1; store = 1'b1; dirty = 1'b0; addr = 32'h0000_4010;
    idle_miss("both.miss");
    for (int k = 0; k < 4; k++)
      beat("both.rf", 1'b0, 32'(32'h4010 + 4 * k), 2'(k), 1'b1);
    update_cycle("both.upd");
    hit_cycle("both.hit");
    load = 1'b0; store = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
